// File: rtl/erro_delta_condicionador.sv
// -----------------------------------------------------------------------------
// erro_delta_condicionador
//   Input-conditioning stage for the fuzzy processor. It samples the setpoint
//   and the plant measurement, then derives the error E and the change of
//   error dE. Both values are scaled, saturated and offset into 8-bit unsigned
//   universes, where 128 represents zero. The block then opens the EN_REGRAS
//   window, during which the downstream inference chain runs.
//
//   Ports
//     clk_0          : system clock, rising edge
//     Srst           : synchronous active-high reset
//     Setpoint       : unsigned reference value (8 bit)
//     Medida         : unsigned plant measurement (8 bit)
//     Amostra_valida : single-cycle sample strobe
//     Pronto         : high while a new sample can be accepted (IDLE)
//     Entrada_01     : conditioned E, offset-binary (8 bit)
//     Entrada_02     : conditioned dE, offset-binary (8 bit)
//     EN_REGRAS      : inference enable window, JANELA cycles long
//     Overrun        : sticky, a strobe arrived while Pronto was low
//
//   Parameters
//     JANELA   : enable window length in cycles (2..255)
//     GANHO_E  : left-shift applied to E before saturation (0..3)
//     GANHO_DE : left-shift applied to dE before saturation (0..3)
//
//   Build option
//     FILTRO_DELTA_EN : when defined, dE is averaged with the previous
//                       unfiltered dE, (dE + dE_ant) >>> 1, before scaling.
// -----------------------------------------------------------------------------
module erro_delta_condicionador #(
  parameter int unsigned JANELA   = 16,
  parameter int unsigned GANHO_E  = 0,
  parameter int unsigned GANHO_DE = 0
) (
  input  logic       clk_0,
  input  logic       Srst,
  input  logic [7:0] Setpoint,
  input  logic [7:0] Medida,
  input  logic       Amostra_valida,
  output logic       Pronto,
  output logic [7:0] Entrada_01,
  output logic [7:0] Entrada_02,
  output logic       EN_REGRAS,
  output logic       Overrun
);

  localparam int unsigned DW  = 8;        // sample / universe width
  localparam int unsigned EW  = DW + 1;   // E: -255..255
  localparam int unsigned DEW = EW + 1;   // dE: -510..510
  localparam int unsigned DSW = DEW + 1;  // dE + dE_ant before halving
  localparam int unsigned SW  = DEW + 3;  // headroom for a shift of up to 3
  localparam int unsigned CW  = 8;        // window counter

  localparam logic [DW-1:0]        ZERO_OFS = DW'(128);
  localparam logic signed [SW-1:0] SAT_MAX  = SW'(127);
  localparam logic signed [SW-1:0] SAT_MIN  = -SW'(128);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] CALC         = 2'd1;
  localparam logic [1:0] PUBLICA      = 2'd2;
  localparam logic [1:0] JANELA_ATIVA = 2'd3;

  // Registered state
  logic [1:0]           state_q,    state_d;
  logic [DW-1:0]        sp_q,       sp_d;
  logic [DW-1:0]        med_q,      med_d;
  logic signed [EW-1:0] e_q,        e_d;
  logic signed [DEW-1:0] de_q,      de_d;
  logic signed [EW-1:0] erro_ant_q, erro_ant_d;
  logic                 primeira_q, primeira_d;
  logic [CW-1:0]        cnt_q,      cnt_d;
  logic [DW-1:0]        ent1_q,     ent1_d;
  logic [DW-1:0]        ent2_q,     ent2_d;
  logic                 en_q,       en_d;
  logic                 ovr_q,      ovr_d;
  logic                 pronto_q,   pronto_d;
`ifdef FILTRO_DELTA_EN
  logic signed [DEW-1:0] de_ant_q,  de_ant_d;
`endif

  // Datapath intermediates
  logic signed [EW-1:0]  e_calc_c;
  logic signed [DEW-1:0] de_raw_c;
  logic signed [DEW-1:0] de_sel_c;

  // Maps a scaled value to the 0..255 universe: clamp to -128..127, then add 128.
  function automatic logic [DW-1:0] sat_offset(input logic signed [SW-1:0] v);
    logic [DW-1:0] r;
    if (v > SAT_MAX) begin
      r = DW'(255);
    end else if (v < SAT_MIN) begin
      r = DW'(0);
    end else begin
      r = DW'(v - SAT_MIN);
    end
    return r;
  endfunction

  // Error and change of error from the latched sample. The first sample after
  // reset has no history, so its dE is forced to zero.
  always_comb begin
    e_calc_c = $signed({1'b0, sp_q}) - $signed({1'b0, med_q});
    de_raw_c = primeira_q ? '0 : (DEW'(e_calc_c) - DEW'(erro_ant_q));
  end

`ifdef FILTRO_DELTA_EN
  // Two-tap average of the raw dE. The arithmetic shift floors toward -inf.
  logic signed [DSW-1:0] de_sum_c;
  always_comb begin
    de_sum_c = DSW'(de_raw_c) + DSW'(de_ant_q);
    de_sel_c = DEW'(de_sum_c >>> 1);
  end
`else
  always_comb begin
    de_sel_c = de_raw_c;
  end
`endif

  // Next-state and next-value logic
  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    med_d      = med_q;
    e_d        = e_q;
    de_d       = de_q;
    erro_ant_d = erro_ant_q;
    primeira_d = primeira_q;
    cnt_d      = cnt_q;
    ent1_d     = ent1_q;
    ent2_d     = ent2_q;
    en_d       = en_q;
    ovr_d      = ovr_q;
`ifdef FILTRO_DELTA_EN
    de_ant_d   = de_ant_q;
`endif

    case (state_q)
      IDLE: begin
        if (Amostra_valida) begin
          sp_d    = Setpoint;
          med_d   = Medida;
          state_d = CALC;
        end
      end
      CALC: begin
        e_d        = e_calc_c;
        de_d       = de_sel_c;
        erro_ant_d = e_calc_c;
        primeira_d = 1'b0;
`ifdef FILTRO_DELTA_EN
        de_ant_d   = de_raw_c;
`endif
        state_d    = PUBLICA;
      end
      PUBLICA: begin
        ent1_d  = sat_offset(SW'(e_q)  <<< GANHO_E);
        ent2_d  = sat_offset(SW'(de_q) <<< GANHO_DE);
        en_d    = 1'b1;
        cnt_d   = CW'(JANELA - 1);
        state_d = JANELA_ATIVA;
      end
      JANELA_ATIVA: begin
        // The load value of JANELA-1 plus the terminal cycle keeps EN high JANELA cycles.
        if (cnt_q == '0) begin
          en_d    = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
      end
    endcase

    // A strobe outside IDLE is dropped. It is remembered only through the sticky flag.
    if (Amostra_valida && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end

    pronto_d = (state_d == IDLE);
  end

  // State and output registers
  always_ff @(posedge clk_0) begin
    if (Srst) begin
      state_q    <= IDLE;
      sp_q       <= '0;
      med_q      <= '0;
      e_q        <= '0;
      de_q       <= '0;
      erro_ant_q <= '0;
      primeira_q <= 1'b1;
      cnt_q      <= '0;
      ent1_q     <= ZERO_OFS;
      ent2_q     <= ZERO_OFS;
      en_q       <= 1'b0;
      ovr_q      <= 1'b0;
      pronto_q   <= 1'b1;
`ifdef FILTRO_DELTA_EN
      de_ant_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      med_q      <= med_d;
      e_q        <= e_d;
      de_q       <= de_d;
      erro_ant_q <= erro_ant_d;
      primeira_q <= primeira_d;
      cnt_q      <= cnt_d;
      ent1_q     <= ent1_d;
      ent2_q     <= ent2_d;
      en_q       <= en_d;
      ovr_q      <= ovr_d;
      pronto_q   <= pronto_d;
`ifdef FILTRO_DELTA_EN
      de_ant_q   <= de_ant_d;
`endif
    end
  end

  assign Pronto     = pronto_q;
  assign Entrada_01 = ent1_q;
  assign Entrada_02 = ent2_q;
  assign EN_REGRAS  = en_q;
  assign Overrun    = ovr_q;

endmodule

// File: tb/tb_erro_delta_condicionador.sv
// -----------------------------------------------------------------------------
// tb_erro_delta_condicionador
//   Testbench for erro_delta_condicionador. It runs a default-parameter
//   instance alongside a gain instance (GANHO_E=2, GANHO_DE=1) and checks both
//   against an arithmetic reference model of the conditioning rules. The model
//   also covers the FILTRO_DELTA_EN build option.
// -----------------------------------------------------------------------------
module tb_erro_delta_condicionador;

  localparam int unsigned JAN  = 16;
  localparam int unsigned G_E  = 2;
  localparam int unsigned G_DE = 1;

  logic       clk_0 = 1'b0;
  logic       Srst;
  logic [7:0] Setpoint;
  logic [7:0] Medida;
  logic       Amostra_valida;

  logic       pronto,   pronto_g;
  logic [7:0] ent1,     ent1_g;
  logic [7:0] ent2,     ent2_g;
  logic       en,       en_g;
  logic       ovr,      ovr_g;

  erro_delta_condicionador #(.JANELA(JAN), .GANHO_E(0), .GANHO_DE(0)) u_dut (
    .clk_0(clk_0), .Srst(Srst), .Setpoint(Setpoint), .Medida(Medida),
    .Amostra_valida(Amostra_valida), .Pronto(pronto), .Entrada_01(ent1),
    .Entrada_02(ent2), .EN_REGRAS(en), .Overrun(ovr)
  );

  erro_delta_condicionador #(.JANELA(JAN), .GANHO_E(G_E), .GANHO_DE(G_DE)) u_dut_g (
    .clk_0(clk_0), .Srst(Srst), .Setpoint(Setpoint), .Medida(Medida),
    .Amostra_valida(Amostra_valida), .Pronto(pronto_g), .Entrada_01(ent1_g),
    .Entrada_02(ent2_g), .EN_REGRAS(en_g), .Overrun(ovr_g)
  );

  always #5 clk_0 = ~clk_0;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model
  int m_ant, m_de_ant, exp1, exp2, exp1g, exp2g;
  bit m_prim, m_ovr;

  function automatic int conv(input int x, input int g);
    int v;
    v = x * (1 << g);
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return v + 128;
  endfunction

  function automatic int floor_half(input int s);
    return (s >= 0) ? s / 2 : -((-s + 1) / 2);
  endfunction

  task automatic model_reset();
    m_ant = 0; m_de_ant = 0; m_prim = 1'b1; m_ovr = 1'b0;
  endtask

  task automatic model_sample(input int sp, input int med);
    int e, de, du;
    e  = sp - med;
    de = m_prim ? 0 : e - m_ant;
    du = de;
`ifdef FILTRO_DELTA_EN
    du = floor_half(de + m_de_ant);
`endif
    m_de_ant = de;
    m_ant    = e;
    m_prim   = 1'b0;
    exp1  = conv(e, 0);
    exp2  = conv(du, 0);
    exp1g = conv(e, G_E);
    exp2g = conv(du, G_DE);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_pronto"}, pronto, 1);
    check_val({tag, "_en"},     en,     0);
    check_val({tag, "_ovr"},    ovr,    0);
    check_val({tag, "_e1"},     ent1,   128);
    check_val({tag, "_e2"},     ent2,   128);
    check_val({tag, "_e1g"},    ent1_g, 128);
    check_val({tag, "_en_g"},   en_g,   0);
  endtask

  // One sample transaction, called at a falling edge with the DUT in IDLE.
  // ov_at / rst_at select a window cycle (1-based) for a dropped strobe or reset; 0 = none.
  task automatic run_sample(input int sp, input int med, input int ov_at, input int rst_at);
    int  hi;
    bit  unstable, busy_err, en_g_err;
    Setpoint = 8'(sp); Medida = 8'(med); Amostra_valida = 1'b1;
    check_val("pronto_idle", pronto, 1);
    model_sample(sp, med);
    @(negedge clk_0);
    Amostra_valida = 1'b0;
    check_val("pronto_calc", pronto, 0);
    check_val("en_calc", en, 0);
    @(negedge clk_0);
    check_val("en_publica", en, 0);
    @(negedge clk_0);
    check_val("en_rise", en, 1);
    check_val("entrada_01", ent1, exp1);
    check_val("entrada_02", ent2, exp2);
    check_val("entrada_01_gain", ent1_g, exp1g);
    check_val("entrada_02_gain", ent2_g, exp2g);
    hi = 0; unstable = 0; busy_err = 0; en_g_err = 0;
    while (en === 1'b1 && hi < 300) begin
      hi++;
      if (ent1 !== 8'(exp1) || ent2 !== 8'(exp2) || ent1_g !== 8'(exp1g)) unstable = 1;
      if (pronto !== 1'b0) busy_err = 1;
      if (en_g !== 1'b1) en_g_err = 1;
      Amostra_valida = 1'b0;
      if (hi == ov_at) begin
        Setpoint = 8'd50; Medida = 8'd10; Amostra_valida = 1'b1;
        m_ovr = 1'b1;
      end
      if (hi == rst_at) Srst = 1'b1;
      @(negedge clk_0);
      if (hi == rst_at) break;
    end
    Amostra_valida = 1'b0;
    check_val("window_stable", unstable, 0);
    check_val("pronto_window", busy_err, 0);
    check_val("en_gain_window", en_g_err, 0);
    if (rst_at != 0 && hi == rst_at) begin
      check_reset_state("rst_mid");
      Srst = 1'b0;
      model_reset();
    end else begin
      check_val("window_len", hi, JAN);
      check_val("pronto_back", pronto, 1);
      check_val("overrun", ovr, m_ovr);
      check_val("overrun_gain", ovr_g, m_ovr);
    end
    repeat ($urandom_range(0, 2)) @(negedge clk_0);
  endtask

  initial begin
    int ov, rs;
    Srst = 1'b1; Amostra_valida = 1'b0; Setpoint = '0; Medida = '0;
    repeat (2) @(negedge clk_0);
    check_reset_state("reset");
    Srst = 1'b0;
    model_reset();
    @(negedge clk_0);

    run_sample(100, 80, 0, 0);   // first sample: 148 / 128
    run_sample(100, 90, 0, 0);   // dE = -10
    run_sample(255, 0, 0, 0);    // E saturates high
    run_sample(0, 255, 0, 0);    // E and dE saturate low
    run_sample(120, 100, 0, 0);  // gain instance: 208
    run_sample(100, 120, 0, 0);  // gain instance: 48
    run_sample(30, 20, 3, 0);    // dropped strobe mid-window
    run_sample(40, 40, 0, 0);    // still uses prior erro_ant
    run_sample(70, 60, 0, 5);    // reset at window cycle 5
    run_sample(90, 60, 0, 0);    // history cleared: dE forced to zero

    for (int i = 0; i < 40; i++) begin
      ov = 0; rs = 0;
      if ($urandom_range(0, 3) == 0)      ov = $urandom_range(1, JAN);
      else if ($urandom_range(0, 7) == 0) rs = $urandom_range(1, JAN);
      run_sample($urandom_range(0, 255), $urandom_range(0, 255), ov, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
